// File: rtl/stream_demux_reg_if.sv
// Stream demux handshake bundle: one producer side, CH consumer lanes.
// in_bcast exists only when DEMUX_BROADCAST_EN is defined.
interface stream_demux_reg_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int SEL_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
`ifdef DEMUX_BROADCAST_EN
    logic              in_bcast;
`endif
    logic [CH-1:0]        out_valid;
    logic [CH-1:0]        out_ready;
    logic [CH*DATA_W-1:0] out_data;

`ifdef DEMUX_BROADCAST_EN
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/stream_demux_reg.sv
// Registered 1-to-CH stream demux with per-channel one-entry slots.
// Optional broadcast to all channels via DEMUX_BROADCAST_EN.
module stream_demux_reg #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_demux_reg_if.slave bus,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    localparam logic [SEL_W:0]   CH_L    = (SEL_W+1)'(CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t             state_q [CH];
    slot_t             state_d [CH];
    logic [DATA_W-1:0] data_q  [CH];

    logic                 bcast;
    logic                 in_range;
    logic                 rdy;
    logic                 accept;
    logic                 drop;
    logic [CH-1:0]        valid_vec;
    logic [CH-1:0]        can_load;
    logic [CH-1:0]        sel_hit;
    logic [CH-1:0]        load_mask;
    logic [CH-1:0]        load;
    logic [CH*DATA_W-1:0] data_vec;

`ifdef DEMUX_BROADCAST_EN
    assign bcast = bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign in_range = {1'b0, bus.in_sel} < CH_L;

    // Slot view: which lanes hold a beat and which can take one this cycle
    always_comb begin
        valid_vec = '0;
        sel_hit   = '0;
        for (int c = 0; c < CH; c++) begin
            valid_vec[c] = (state_q[c] == FULL);
            sel_hit[c]   = (bus.in_sel == SEL_W'(c));
        end
        can_load = ~valid_vec | bus.out_ready;
    end

    // Input ready and target lanes; out-of-range beats are always taken
    always_comb begin
        rdy       = 1'b1;
        load_mask = '0;
        if (bcast) begin
            rdy       = &can_load;
            load_mask = '1;
        end else if (in_range) begin
            rdy       = |(sel_hit & can_load);
            load_mask = sel_hit;
        end
    end

    assign accept = bus.in_valid & rdy;
    assign load   = load_mask & {CH{accept}};
    assign drop   = accept & ~bcast & ~in_range;

    // Per-lane slot next state; a load while draining keeps the lane FULL
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
        end
        for (int c = 0; c < CH; c++) begin
            unique case (state_q[c])
                EMPTY: begin
                    if (load[c]) begin
                        state_d[c] = FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready[c] && !load[c]) begin
                        state_d[c] = EMPTY;
                    end
                end
            endcase
        end
    end

    // Slot state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= EMPTY;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
            end
        end
    end

    // Lane payload registers; only written on a load, so stalled data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                data_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (load[c]) begin
                    data_q[c] <= bus.in_data;
                end
            end
        end
    end

    // Saturating count of discarded out-of-range beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Pack lane registers onto the flat output bus
    always_comb begin
        data_vec = '0;
        for (int c = 0; c < CH; c++) begin
            data_vec[c*DATA_W +: DATA_W] = data_q[c];
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = valid_vec;
    assign bus.out_data  = data_vec;
endmodule

// File: doc/stream_demux_reg.md
# stream_demux_reg

Parametrised, registered 1-to-CH stream demultiplexer with valid/ready handshaking. Each accepted input beat is steered by its select field into a one-entry output register for the chosen channel, so each channel has independent backpressure. Beats with an out-of-range select are dropped and counted. The block sits between a single producer and CH downstream consumers and is the clocked, flow-controlled generalisation of the team's 1-to-4 combinational demux.

## Interface
Parameters:
- DATA_W, 8: payload width in bits (≥1).
- CH, 4: number of output channels (2..16).
- SEL_W, 2: select width; must satisfy 2**SEL_W ≥ CH.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  broadcast request; present only with DEMUX_BROADCAST_EN.
- out_valid  out  CH  per-channel valid; bit c belongs to channel c.
- out_ready  in  CH  per-channel ready.
- out_data  out  CH*DATA_W  channel c occupies [c*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of dropped beats, saturating.

## Operation
- Per channel c, slot state is EMPTY (out_valid[c]=0) or FULL (out_valid[c]=1).
  - EMPTY→FULL on a load into c.
  - FULL→EMPTY on out_ready[c] with no load.
  - FULL→FULL on out_ready[c] with a simultaneous load; this is pass-through and the register takes the new data.
  - FULL with no out_ready[c]: hold data and valid.
- can_load[c] = !out_valid[c] || out_ready[c].
- Routed beat (in_sel < CH, no broadcast): in_ready = can_load[in_sel]. On a handshake, out_data[c] ← in_data and out_valid[c] ← 1 for c = in_sel only.
- Out-of-range beat (in_sel ≥ CH, no broadcast): in_ready = 1. On the handshake the beat is discarded, no channel changes, and drop_cnt increments. drop_cnt saturates at 2**CNT_W−1.
- in_ready depends combinationally on in_sel, in_bcast and out_ready. out_valid and out_data are driven only from registers.
- No channel's data changes while it is FULL and its out_ready is low. This holds regardless of input activity.
- Other channels' slots are unaffected by a load into channel c.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, drop_cnt = 0. in_ready then follows the combinational rule (1 for any select).
- Reset deasserted mid-transfer: all pending beats are lost, with no partial state retained.
- Latency: a beat accepted at edge k drives out_valid/out_data from edge k onward, i.e. visible in the cycle after acceptance.
- Throughput: one beat per cycle into any single channel when its out_ready is held high.
- Handshake rules:
  - Producer must hold in_data/in_sel/in_bcast stable while in_valid && !in_ready.
  - The block holds out_data[c] stable while out_valid[c] && !out_ready[c].

## Configuration
- DEMUX_BROADCAST_EN defined:
  - in_bcast port exists.
  - With in_bcast=1, in_sel is ignored and in_ready = AND of can_load[c] over all c.
  - On the handshake, every channel loads in_data and sets out_valid. drop_cnt is unaffected.
- DEMUX_BROADCAST_EN undefined: in_bcast port is absent and behaviour is as if in_bcast=0.

## Test plan
- Reset: assert rst_n=0 mid-traffic with channel 2 FULL → out_valid=4'b0000, out_data=0 and drop_cnt=0 immediately without a clock edge; in_ready=1.
- Routing: send 0xA5 with sel=1 and 0x3C with sel=3, with all out_ready=1 → out_valid pulses 4'b0010 then 4'b1000, carrying data 0xA5 then 0x3C, one cycle after each accept.
- Backpressure:
  - Set out_ready[0]=0 and send 0x11 then 0x22 to sel=0 → 0x11 is held and in_ready=0 for the second beat.
  - Raise out_ready[0] → 0x11 is consumed and 0x22 is loaded on the same edge (pass-through); out_valid[0] stays 1.
- Independence: channel 0 FULL and stalled, then send 0x55 to sel=2 → accepted immediately; channel 0 data is unchanged.
- Drop/saturation: with CH=3 and SEL_W=2, send 300 beats with sel=3 → in_ready=1 every cycle, no out_valid asserted, drop_cnt=255 (CNT_W=8).
- Broadcast (macro defined):
  - in_bcast=1, data 0x7E, out_ready=4'b1111 → out_valid=4'b1111 and all channels carry 0x7E.
  - Repeat with channel 1 FULL and stalled → in_ready=0 until out_ready[1] rises.
